// File: rtl/spi_types.sv
// Shared SPI transaction types.
// Used by the controller and its users.
package spi_types;

   typedef enum logic [2:0] {
      WRITE_8         = 3'd0,
      WRITE_16        = 3'd1,
      WRITE_8_READ_8  = 3'd2,
      WRITE_8_READ_16 = 3'd3,
      WRITE_8_READ_24 = 3'd4
   } spi_transaction_t;

endpackage

// File: rtl/spi_controller.sv
// SPI mode-0 controller: write-then-read transactions,
// sclk = clk/2, valid/ready request and result ports.
module spi_controller
   import spi_types::*;
(
   input  logic             clk,
   input  logic             rst,
   output logic             sclk,
   output logic             csb,
   output logic             mosi,
   input  logic             miso,
   input  spi_transaction_t spi_mode,
   output logic             i_ready,
   input  logic             i_valid,
   input  logic [15:0]      i_data,
   input  logic             o_ready,
   output logic             o_valid,
   output logic [23:0]      o_data
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      DONE     = 2'd2,
      WAIT_OUT = 2'd3
   } state_t;

   localparam logic [5:0] WR_BITS_8  = 6'd8;
   localparam logic [5:0] WR_BITS_16 = 6'd16;
   localparam logic [5:0] RD_BITS_8  = 6'd8;
   localparam logic [5:0] RD_BITS_16 = 6'd16;
   localparam logic [5:0] RD_BITS_24 = 6'd24;

   state_t      state_q, state_d;
   logic        sclk_q, sclk_d;
   logic        csb_q, csb_d;
   logic        mosi_q, mosi_d;
   logic [15:0] tx_q, tx_d;
   logic [23:0] rx_q, rx_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [5:0]  wbits_q, wbits_d;
   logic [5:0]  total_q, total_d;
   logic        rd_q, rd_d;
   logic        ov_q, ov_d;
   logic [23:0] od_q, od_d;

   logic [5:0]  wbits_m;
   logic [5:0]  rbits_m;
   logic        accept;
   logic        last_fall;

   assign accept    = i_valid & (state_q == IDLE);
   assign last_fall = (state_q == SHIFT) & sclk_q
                    & (cnt_q == total_q - 6'd1);

   // Decode requested mode into write/read bit counts
   always_comb begin
      wbits_m = WR_BITS_8;
      rbits_m = 6'd0;
      case (spi_mode)
         WRITE_16:        wbits_m = WR_BITS_16;
         WRITE_8_READ_8:  rbits_m = RD_BITS_8;
         WRITE_8_READ_16: rbits_m = RD_BITS_16;
         WRITE_8_READ_24: rbits_m = RD_BITS_24;
         default:         ;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = SHIFT;
         SHIFT:    if (last_fall) state_d = DONE;
         DONE:     state_d = rd_q ? WAIT_OUT : IDLE;
         WAIT_OUT: if (ov_q && o_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output and datapath next values per state
   always_comb begin
      sclk_d  = sclk_q;
      csb_d   = csb_q;
      mosi_d  = mosi_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      wbits_d = wbits_q;
      total_d = total_q;
      rd_d    = rd_q;
      ov_d    = ov_q;
      od_d    = od_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               csb_d   = 1'b0;
               sclk_d  = 1'b0;
               // write data is left-aligned so bit 15 leads
               if (wbits_m == WR_BITS_16)
                  tx_d = i_data;
               else
                  tx_d = {i_data[7:0], 8'h00};
               mosi_d  = tx_d[15];
               rx_d    = 24'h0;
               cnt_d   = 6'd0;
               wbits_d = wbits_m;
               total_d = wbits_m + rbits_m;
               rd_d    = (rbits_m != 6'd0);
            end
         end
         SHIFT: begin
            if (!sclk_q) begin
               sclk_d = 1'b1;
               if (cnt_q >= wbits_q)
                  rx_d = {rx_q[22:0], miso};
            end else begin
               sclk_d = 1'b0;
               if (last_fall) begin
                  csb_d  = 1'b1;
                  mosi_d = 1'b0;
               end else begin
                  cnt_d  = cnt_q + 6'd1;
                  // zeros shift in, so the read phase drives 0
                  tx_d   = {tx_q[14:0], 1'b0};
                  mosi_d = tx_q[14];
               end
            end
         end
         DONE: begin
            if (rd_q) begin
               ov_d = 1'b1;
               od_d = rx_q;
            end
         end
         WAIT_OUT: begin
            if (o_ready) ov_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_q  <= 1'b0;
         csb_q   <= 1'b1;
         mosi_q  <= 1'b0;
         tx_q    <= 16'h0;
         rx_q    <= 24'h0;
         cnt_q   <= 6'd0;
         wbits_q <= 6'd0;
         total_q <= 6'd0;
         rd_q    <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= 24'h0;
      end else begin
         sclk_q  <= sclk_d;
         csb_q   <= csb_d;
         mosi_q  <= mosi_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         wbits_q <= wbits_d;
         total_q <= total_d;
         rd_q    <= rd_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
      end
   end

   assign sclk    = sclk_q;
   assign csb     = csb_q;
   assign mosi    = mosi_q;
   assign o_valid = ov_q;
   assign o_data  = od_q;
   assign i_ready = (state_q == IDLE);

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: device model on
// the SPI pins plus a result-port monitor.
module tb_spi_controller;
   import spi_types::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             sclk, csb, mosi, miso;
   spi_transaction_t spi_mode;
   logic             i_ready, i_valid;
   logic [15:0]      i_data;
   logic             o_ready, o_valid;
   logic [23:0]      o_data;

   spi_controller dut (
      .clk(clk), .rst(rst), .sclk(sclk), .csb(csb),
      .mosi(mosi), .miso(miso), .spi_mode(spi_mode),
      .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          wb;
      int          rb;
      logic [15:0] wv;
      logic [23:0] rw;
   } exp_t;

   exp_t        exp_q[$];
   logic [23:0] rd_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          ready_mode = 0;

   task automatic chk(input string nm,
                      input logic [47:0] got,
                      input logic [47:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, got, want);
      end
   endtask

   // Reference: bit counts from the transaction table
   function automatic exp_t model(input logic [2:0] m,
                                  input logic [15:0] d,
                                  input logic [23:0] r);
      exp_t e;
      e.wb = 8;
      e.rb = 0;
      case (m)
         3'd1: e.wb = 16;
         3'd2: e.rb = 8;
         3'd3: e.rb = 16;
         3'd4: e.rb = 24;
         default: ;
      endcase
      e.wv = (e.wb == 16) ? d : {8'h00, d[7:0]};
      e.rw = r & 24'((32'h1 << e.rb) - 1);
      return e;
   endfunction

   // Device model and monitors, sampled on the falling clk edge
   initial begin
      int          cyc, nrise, k;
      logic [47:0] cap;
      logic        psclk, pcsb, pov, phs;
      logic [23:0] pod;
      exp_t        e;
      cyc = 0; nrise = 0; cap = '0;
      psclk = 1'b0; pcsb = 1'b1; pov = 1'b0;
      phs = 1'b0; pod = '0;
      miso = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cyc = 0; nrise = 0; cap = '0;
            psclk = 1'b0; pcsb = 1'b1;
            pov = 1'b0; phs = 1'b0; pod = '0;
            exp_q.delete();
            rd_q.delete();
         end else begin
            if (!csb) begin
               cyc++;
               if (sclk && !psclk) begin
                  cap = {cap[46:0], mosi};
                  nrise++;
               end
               chk("i_ready_busy", 48'(i_ready), 48'd0);
               miso = 1'($urandom);
               if (exp_q.size() > 0) begin
                  e = exp_q[0];
                  k = nrise;
                  if (k >= e.wb && k < e.wb + e.rb)
                     miso = e.rw[e.rb - 1 - (k - e.wb)];
               end
            end else if (!pcsb) begin
               if (exp_q.size() == 0) begin
                  chk("txn_expected", 48'd0, 48'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("sclk_rises", 48'(nrise),
                      48'(e.wb + e.rb));
                  chk("csb_low_clk", 48'(cyc),
                      48'(2 * (e.wb + e.rb)));
                  chk("mosi_stream", cap,
                      {32'h0, e.wv} << e.rb);
                  chk("sclk_end", 48'(sclk), 48'd0);
                  chk("mosi_end", 48'(mosi), 48'd0);
                  if (e.rb != 0) rd_q.push_back(e.rw);
               end
               cyc = 0; nrise = 0; cap = '0;
            end
            if (pov && !phs) begin
               chk("o_valid_hold", 48'(o_valid), 48'd1);
               chk("o_data_hold", 48'(o_data), 48'(pod));
            end
            if (o_valid && !pov && rd_q.size() == 0)
               chk("o_valid_expected", 48'd0, 48'd1);
            if (o_valid) begin
               chk("i_ready_wait", 48'(i_ready), 48'd0);
               if (o_ready && rd_q.size() > 0)
                  chk("o_data", 48'(o_data),
                      48'(rd_q.pop_front()));
            end
            psclk = sclk;
            pcsb  = csb;
            pov   = o_valid;
            phs   = o_valid && o_ready;
            pod   = o_data;
         end
      end
   end

   // Consumer ready: random, forced low, or forced high
   initial begin
      o_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       o_ready = 1'b0;
            2:       o_ready = 1'b1;
            default: o_ready = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   task automatic send(input logic [2:0] m,
                       input logic [15:0] d,
                       input logic [23:0] r);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      while (!i_ready && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("i_ready_timeout", 48'(t < 300), 48'd1);
      spi_mode = spi_transaction_t'(m);
      i_data   = d;
      i_valid  = 1'b1;
      exp_q.push_back(model(m, d, r));
      @(posedge clk);
      #1;
      i_valid  = 1'b0;
      i_data   = 16'($urandom);
      spi_mode = spi_transaction_t'($urandom_range(0, 7));
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(posedge clk);
      #1;
      while (!(i_ready && !o_valid && exp_q.size() == 0
               && rd_q.size() == 0) && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("idle_timeout", 48'(t < 500), 48'd1);
   endtask

   initial begin
      int t;
      rst      = 1'b0;
      i_valid  = 1'b0;
      i_data   = 16'h0;
      spi_mode = WRITE_8;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_csb", 48'(csb), 48'd1);
      chk("rst_sclk", 48'(sclk), 48'd0);
      chk("rst_mosi", 48'(mosi), 48'd0);
      chk("rst_o_valid", 48'(o_valid), 48'd0);
      chk("rst_o_data", 48'(o_data), 48'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_i_ready", 48'(i_ready), 48'd1);

      send(3'd0, 16'h00AA, 24'h0);
      send(3'd1, 16'h55AA, 24'h0);
      wait_idle();
      chk("w16_i_ready", 48'(i_ready), 48'd1);
      send(3'd2, 16'h0001, 24'h0000FF);
      send(3'd3, 16'd10, 24'h000064);
      send(3'd4, 16'd10, 24'h0003E8);
      wait_idle();

      ready_mode = 1;
      send(3'd2, 16'h003C, 24'h0000A5);
      t = 0;
      while (!o_valid && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("stall_valid_timeout", 48'(t < 100), 48'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("stall_o_valid", 48'(o_valid), 48'd1);
         chk("stall_o_data", 48'(o_data), 48'h0000A5);
         chk("stall_i_ready", 48'(i_ready), 48'd0);
      end
      ready_mode = 2;
      wait_idle();
      chk("held_o_data", 48'(o_data), 48'h0000A5);
      ready_mode = 0;

      send(3'd1, 16'hBEEF, 24'h0);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_csb", 48'(csb), 48'd1);
      chk("abort_sclk", 48'(sclk), 48'd0);
      chk("abort_o_valid", 48'(o_valid), 48'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_i_ready", 48'(i_ready), 48'd1);
      send(3'd1, 16'h1234, 24'h0);
      send(3'd4, 16'h00C3, 24'h5A5A5A);

      for (int i = 0; i < 40; i++)
         send(3'($urandom_range(0, 7)), 16'($urandom),
              24'($urandom));
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
